mips_mc_ctrl: RTL

- Multi-cycle MIPS main controller.
- Sequences the datapath's resettable state registers (PC, IR) and the GPR file / data memory through a per-instruction FSM.
- Drives write enables and mux/op selects from FSM state plus the IR opcode/funct fields.
- Sits beside the datapath; consumes IR fields and the ALU zero flag.

---
 rtl/mips_ctrl_pkg.sv | 52 +++++
 rtl/mips_ctrl_decode.sv | 36 +++
 rtl/mips_mc_ctrl.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS main controller.
// Contents: opcode/funct constants, FSM state codes, and the select
// encodings for npc_op, alu_op, ext_op, gpr_sel and wd_sel.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE   = 6'b000000;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_LUI     = 6'b001111;
  localparam logic [5:0] OP_LW      = 6'b100011;
  localparam logic [5:0] OP_SW      = 6'b101011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;

  localparam logic [5:0] FUNCT_ADDU = 6'b100001;
  localparam logic [5:0] FUNCT_SUBU = 6'b100011;

  typedef enum logic [3:0] {
    S_FETCH = 4'd0,
    S_DCD   = 4'd1,
    S_EXE   = 4'd2,
    S_ALUWB = 4'd3,
    S_MA    = 4'd4,
    S_MR    = 4'd5,
    S_MWB   = 4'd6,
    S_MW    = 4'd7,
    S_BR    = 4'd8,
    S_JMP   = 4'd9
  } state_t;

  localparam logic [1:0] NPC_PC4   = 2'b00;
  localparam logic [1:0] NPC_BR    = 2'b01;
  localparam logic [1:0] NPC_JUMP  = 2'b10;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_OR    = 2'b10;
  localparam logic [1:0] ALU_PASSB = 2'b11;

  localparam logic [1:0] EXT_ZERO  = 2'b00;
  localparam logic [1:0] EXT_SIGN  = 2'b01;
  localparam logic [1:0] EXT_HI16  = 2'b10;

  localparam logic [1:0] GPR_RT    = 2'b00;
  localparam logic [1:0] GPR_RD    = 2'b01;
  localparam logic [1:0] GPR_RA    = 2'b10;

  localparam logic [1:0] WD_ALU    = 2'b00;
  localparam logic [1:0] WD_DM     = 2'b01;
  localparam logic [1:0] WD_PC     = 2'b10;

endpackage

// File: rtl/mips_ctrl_decode.sv
// Instruction classifier: op/funct -> one-hot instruction class.
// Ports:
//   op, funct      IR opcode and function fields
//   is_*           exactly one class flag is high; is_illegal covers every
//                  unsupported op and every unsupported funct under op 0
module mips_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output logic       is_rtype_alu,
  output logic       is_ori,
  output logic       is_lui,
  output logic       is_lw,
  output logic       is_sw,
  output logic       is_beq,
  output logic       is_j,
  output logic       is_jal,
  output logic       is_illegal
);

  logic rtype_ok;

  assign rtype_ok     = (funct == FUNCT_ADDU) || (funct == FUNCT_SUBU);
  assign is_rtype_alu = (op == OP_RTYPE) && rtype_ok;
  assign is_ori       = (op == OP_ORI);
  assign is_lui       = (op == OP_LUI);
  assign is_lw        = (op == OP_LW);
  assign is_sw        = (op == OP_SW);
  assign is_beq       = (op == OP_BEQ);
  assign is_j         = (op == OP_J);
  assign is_jal       = (op == OP_JAL);
  assign is_illegal   = !(is_rtype_alu || is_ori || is_lui || is_lw || is_sw ||
                          is_beq || is_j || is_jal);

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS main controller.
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-low reset
//   op, funct, zero   IR fields (stable from DCD onward) and ALU zero flag
//   pc_wr, ir_wr, rf_wr, dm_wr   write enables (all 0 while rst is low)
//   npc_op, alu_op, ext_op, b_sel, gpr_sel, wd_sel   datapath selects
//   state             current FSM state for debug/trace
module mips_mc_ctrl
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pc_wr,
  output logic       ir_wr,
  output logic       rf_wr,
  output logic       dm_wr,
  output logic [1:0] npc_op,
  output logic [1:0] alu_op,
  output logic [1:0] ext_op,
  output logic       b_sel,
  output logic [1:0] gpr_sel,
  output logic [1:0] wd_sel,
  output logic [3:0] state
);

  state_t state_q, state_d;
  logic is_rtype_alu, is_ori, is_lui, is_lw, is_sw;
  logic is_beq, is_j, is_jal, is_illegal;
  logic pc_wr_c, ir_wr_c, rf_wr_c, dm_wr_c, b_sel_c;
  logic [1:0] npc_op_c, alu_op_c, ext_op_c, gpr_sel_c, wd_sel_c;

  mips_ctrl_decode u_decode (
    .op           (op),
    .funct        (funct),
    .is_rtype_alu (is_rtype_alu),
    .is_ori       (is_ori),
    .is_lui       (is_lui),
    .is_lw        (is_lw),
    .is_sw        (is_sw),
    .is_beq       (is_beq),
    .is_j         (is_j),
    .is_jal       (is_jal),
    .is_illegal   (is_illegal)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_FETCH;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d   = S_FETCH;
    pc_wr_c   = 1'b0;
    ir_wr_c   = 1'b0;
    rf_wr_c   = 1'b0;
    dm_wr_c   = 1'b0;
    npc_op_c  = NPC_PC4;
    alu_op_c  = ALU_ADD;
    ext_op_c  = EXT_ZERO;
    b_sel_c   = 1'b0;
    gpr_sel_c = GPR_RT;
    wd_sel_c  = WD_ALU;
    case (state_q)
      S_FETCH: begin
        pc_wr_c = 1'b1;
        ir_wr_c = 1'b1;
        state_d = S_DCD;
      end
      S_DCD: begin
        if (is_rtype_alu || is_ori || is_lui) state_d = S_EXE;
        else if (is_lw || is_sw)              state_d = S_MA;
        else if (is_beq)                      state_d = S_BR;
        else if (is_j || is_jal)              state_d = S_JMP;
        else                                  state_d = S_FETCH;
      end
      // EXE holds the ALU selects for a cycle so the result is settled
      // before ALUWB commits it with the same selects.
      S_EXE, S_ALUWB: begin
        state_d = (state_q == S_EXE) ? S_ALUWB : S_FETCH;
        rf_wr_c = (state_q == S_ALUWB) && !is_illegal;
        if (is_rtype_alu) begin
          alu_op_c  = (funct == FUNCT_SUBU) ? ALU_SUB : ALU_ADD;
          gpr_sel_c = GPR_RD;
        end else if (is_ori) begin
          alu_op_c = ALU_OR;
          b_sel_c  = 1'b1;
        end else if (is_lui) begin
          alu_op_c = ALU_PASSB;
          ext_op_c = EXT_HI16;
          b_sel_c  = 1'b1;
        end
      end
      S_MA, S_MR, S_MWB, S_MW: begin
        ext_op_c = EXT_SIGN;
        b_sel_c  = 1'b1;
        case (state_q)
          S_MA:    state_d = is_lw ? S_MR : S_MW;
          S_MR:    state_d = S_MWB;
          S_MWB: begin
            rf_wr_c  = 1'b1;
            wd_sel_c = WD_DM;
          end
          default: dm_wr_c = 1'b1;
        endcase
      end
      S_BR: begin
        alu_op_c = ALU_SUB;
        ext_op_c = EXT_SIGN;
        npc_op_c = NPC_BR;
        pc_wr_c  = zero;
      end
      S_JMP: begin
        pc_wr_c  = 1'b1;
        npc_op_c = NPC_JUMP;
        if (is_jal) begin
          rf_wr_c   = 1'b1;
          gpr_sel_c = GPR_RA;
          wd_sel_c  = WD_PC;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  // While reset is held the state already reads FETCH, so the FETCH
  // enables must be masked explicitly; selects are cleared as well.
  assign pc_wr   = rst & pc_wr_c;
  assign ir_wr   = rst & ir_wr_c;
  assign rf_wr   = rst & rf_wr_c;
  assign dm_wr   = rst & dm_wr_c;
  assign b_sel   = rst & b_sel_c;
  assign npc_op  = rst ? npc_op_c  : 2'b00;
  assign alu_op  = rst ? alu_op_c  : 2'b00;
  assign ext_op  = rst ? ext_op_c  : 2'b00;
  assign gpr_sel = rst ? gpr_sel_c : 2'b00;
  assign wd_sel  = rst ? wd_sel_c  : 2'b00;
  assign state   = state_q;

endmodule
